// File: rtl/lru_replacement_policy_multiset.sv
// lru_replacement_policy_multiset
//
// Eviction-policy engine that sits beside a cache controller. It keeps one age
// per way for every set. Within a set the ages are always a permutation of
// 0..NUM_WAYS-1, where 0 is the most recently used way and NUM_WAYS-1 is the
// least recently used way. The policy runs in LRU or FIFO mode and answers
// victim lookups one cycle after each request.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   mode_i           0 = LRU (hits and fills age the set), 1 = FIFO (only fills age it)
//   update_*         access report: strobe, set, one-hot way, alloc(1)/hit(0)
//   victim_req_i     victim lookup for victim_set_i; lock_mask_i excludes ways
//   victim_valid_o   one-cycle response pulse
//   victim_way_o     one-hot victim (held until the next response)
//   victim_id_o      binary victim index (held until the next response)
//   victim_none_o    every way was locked (held until the next response)
//   init_busy_o      age sweep in progress; requests are ignored meanwhile
//   error_o          sticky flag: an update arrived with a non-one-hot way
module lru_replacement_policy_multiset #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 64,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode_i,
  input  logic                update_valid_i,
  input  logic [SET_W-1:0]    update_set_i,
  input  logic [NUM_WAYS-1:0] update_way_i,
  input  logic                update_alloc_i,
  input  logic                victim_req_i,
  input  logic [SET_W-1:0]    victim_set_i,
  input  logic [NUM_WAYS-1:0] lock_mask_i,
  output logic                victim_valid_o,
  output logic [NUM_WAYS-1:0] victim_way_o,
  output logic [WAY_W-1:0]    victim_id_o,
  output logic                victim_none_o,
  output logic                init_busy_o,
  output logic                error_o
);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    ptr_q, ptr_d;
  logic                mode_q, mode_d;
  logic [WAY_W-1:0]    age_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_d [NUM_SETS][NUM_WAYS];
  logic                victim_valid_q, victim_valid_d;
  logic [NUM_WAYS-1:0] victim_way_q, victim_way_d;
  logic [WAY_W-1:0]    victim_id_q, victim_id_d;
  logic                victim_none_q, victim_none_d;
  logic                init_busy_q, init_busy_d;
  logic                error_q, error_d;

  logic                upd_onehot;
  logic                mode_change;
  logic [WAY_W-1:0]    hit_id;
  logic [WAY_W-1:0]    hit_age;
  logic                vict_found;
  logic [WAY_W-1:0]    vict_id;
  logic [WAY_W-1:0]    vict_age;

  // A one-hot vector is non-zero and has no second bit left once its lowest
  // set bit is cleared.
  assign upd_onehot  = (update_way_i != '0) &&
                       ((update_way_i & (update_way_i - NUM_WAYS'(1))) == '0);
  assign mode_change = (mode_i != mode_q);

  // Binary index of the reported way. The result is only used when the way
  // vector is one-hot.
  always_comb begin
    hit_id = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (update_way_i[i]) hit_id = WAY_W'(i);
    end
  end

  assign hit_age = age_q[update_set_i][hit_id];

  // Pick the oldest unlocked way. Ages within a set are unique, so a strict
  // greater-than comparison never has to break a tie.
  always_comb begin
    vict_found = 1'b0;
    vict_id    = '0;
    vict_age   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!lock_mask_i[i] && (!vict_found || (age_q[victim_set_i][i] > vict_age))) begin
        vict_found = 1'b1;
        vict_id    = WAY_W'(i);
        vict_age   = age_q[victim_set_i][i];
      end
    end
  end

  // Next-state logic.
  // In INIT, one set is rewritten to the identity permutation per cycle.
  // A mode flip in either state restarts the sweep from set 0.
  // In IDLE, a valid update moves the touched way to age 0 and shifts every
  // younger way up by one; ways older than the touched way keep their age.
  // A victim request is answered from the pre-update ages.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    mode_d         = mode_i;
    age_d          = age_q;
    error_d        = error_q;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;
    victim_id_d    = victim_id_q;
    victim_none_d  = victim_none_q;

    case (state_q)
      ST_INIT: begin
        if (mode_change) begin
          ptr_d = '0;
        end else begin
          for (int i = 0; i < NUM_WAYS; i++) begin
            age_d[ptr_q][i] = WAY_W'(i);
          end
          ptr_d = ptr_q + SET_W'(1);
          if (ptr_q == SET_W'(NUM_SETS - 1)) state_d = ST_IDLE;
        end
      end

      default: begin
        if (mode_change) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end else if (update_valid_i) begin
          if (!upd_onehot) begin
            error_d = 1'b1;
          end else if (!mode_q || update_alloc_i) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
              if (WAY_W'(i) == hit_id) begin
                age_d[update_set_i][i] = '0;
              end else if (age_q[update_set_i][i] < hit_age) begin
                age_d[update_set_i][i] = age_q[update_set_i][i] + WAY_W'(1);
              end
            end
          end
        end

        if (victim_req_i) begin
          victim_valid_d = 1'b1;
          victim_none_d  = !vict_found;
          victim_id_d    = vict_found ? vict_id : '0;
          victim_way_d   = vict_found ? (NUM_WAYS'(1) << vict_id) : '0;
        end
      end
    endcase
  end

  assign init_busy_d = (state_d == ST_INIT);

  // State and registered outputs.
  // The ages reset to the identity permutation, which the sweep then
  // rewrites anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      ptr_q          <= '0;
      mode_q         <= 1'b0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_id_q    <= '0;
      victim_none_q  <= 1'b0;
      init_busy_q    <= 1'b1;
      error_q        <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
          age_q[s][i] <= WAY_W'(i);
        end
      end
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      mode_q         <= mode_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_id_q    <= victim_id_d;
      victim_none_q  <= victim_none_d;
      init_busy_q    <= init_busy_d;
      error_q        <= error_d;
      age_q          <= age_d;
    end
  end

  assign victim_valid_o = victim_valid_q;
  assign victim_way_o   = victim_way_q;
  assign victim_id_o    = victim_id_q;
  assign victim_none_o  = victim_none_q;
  assign init_busy_o    = init_busy_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_lru_replacement_policy_multiset.sv
// Testbench for lru_replacement_policy_multiset.
//
// The reference model keeps each set as a recency list, with the most recent
// way first. A victim is the last unlocked entry in that list. Every expected
// response is queued together with the cycle it is due in, and the monitor
// pops the queue when the DUT presents a response.
module tb_lru_replacement_policy_multiset;

  localparam int NW = 8;
  localparam int NS = 64;
  localparam int WW = 3;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mode_i = 1'b0;
  logic          update_valid_i = 1'b0;
  logic [SW-1:0] update_set_i = '0;
  logic [NW-1:0] update_way_i = '0;
  logic          update_alloc_i = 1'b0;
  logic          victim_req_i = 1'b0;
  logic [SW-1:0] victim_set_i = '0;
  logic [NW-1:0] lock_mask_i = '0;
  logic          victim_valid_o;
  logic [NW-1:0] victim_way_o;
  logic [WW-1:0] victim_id_o;
  logic          victim_none_o;
  logic          init_busy_o;
  logic          error_o;

  lru_replacement_policy_multiset #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode_i         (mode_i),
    .update_valid_i (update_valid_i),
    .update_set_i   (update_set_i),
    .update_way_i   (update_way_i),
    .update_alloc_i (update_alloc_i),
    .victim_req_i   (victim_req_i),
    .victim_set_i   (victim_set_i),
    .lock_mask_i    (lock_mask_i),
    .victim_valid_o (victim_valid_o),
    .victim_way_o   (victim_way_o),
    .victim_id_o    (victim_id_o),
    .victim_none_o  (victim_none_o),
    .init_busy_o    (init_busy_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int due;
    bit none;
    int id;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   order [NS][NW];
  bit   model_mode = 1'b0;
  bit   model_err = 1'b0;
  bit   last_none = 1'b0;
  int   last_id = 0;
  int   last_way = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // A freshly swept set holds ways in index order, with way 0 most recent.
  task automatic modelReset();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NW; k++)
        order[s][k] = k;
  endtask

  function automatic int modelVictim(input int s, input logic [NW-1:0] mask);
    for (int k = NW - 1; k >= 0; k--)
      if (!mask[order[s][k]]) return order[s][k];
    return -1;
  endfunction

  task automatic modelTouch(input int s, input int w);
    int p = 0;
    for (int k = 0; k < NW; k++)
      if (order[s][k] == w) p = k;
    for (int k = p; k > 0; k--)
      order[s][k] = order[s][k-1];
    order[s][0] = w;
  endtask

  function automatic int wayIndex(input logic [NW-1:0] oh);
    int r = 0;
    for (int i = 0; i < NW; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

  // Issue one cycle of stimulus while the DUT is idle, then advance the model.
  task automatic applyStimulus(input bit uv, input int us, input logic [NW-1:0] uw, input bit ua,
                               input bit vr, input int vs, input logic [NW-1:0] mask);
    exp_t e;
    int   v;
    update_valid_i = uv;
    update_set_i   = SW'(us);
    update_way_i   = uw;
    update_alloc_i = ua;
    victim_req_i   = vr;
    victim_set_i   = SW'(vs);
    lock_mask_i    = mask;
    if (vr) begin
      v     = modelVictim(vs, mask);
      e.due = cyc + 1;
      e.none = (v < 0);
      e.id   = (v < 0) ? 0 : v;
      expq.push_back(e);
    end
    if (uv) begin
      if ($countones(uw) != 1) model_err = 1'b1;
      else if (!model_mode || ua) modelTouch(us, wayIndex(uw));
    end
    @(posedge clk);
    #1;
    update_valid_i = 1'b0;
    victim_req_i   = 1'b0;
  endtask

  // Random traffic that the DUT must ignore while it sweeps.
  task automatic junkCycle();
    update_valid_i = 1'($urandom);
    update_set_i   = SW'($urandom);
    update_way_i   = NW'($urandom);
    update_alloc_i = 1'($urandom);
    victim_req_i   = 1'($urandom);
    victim_set_i   = SW'($urandom);
    lock_mask_i    = NW'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic waitSweep(input string name);
    int n = 0;
    while (init_busy_o === 1'b1 && n < 200) begin
      junkCycle();
      n++;
    end
    update_valid_i = 1'b0;
    victim_req_i   = 1'b0;
    checkOutput(name, n, NS);
    modelReset();
  endtask

  task automatic changeMode(input bit m, input string name);
    mode_i     = m;
    model_mode = m;
    @(posedge clk);
    #1;
    checkOutput("busy_after_mode_change", init_busy_o, 1);
    waitSweep(name);
  endtask

  task automatic randomPhase(input int n);
    logic [NW-1:0] uw, mask;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) uw = NW'($urandom);
      else uw = NW'(1) << $urandom_range(0, NW - 1);
      if ($urandom_range(0, 9) == 0) mask = '1;
      else mask = NW'($urandom & $urandom & $urandom);
      applyStimulus(1'($urandom), $urandom_range(0, 7), uw, 1'($urandom),
                    ($urandom_range(0, 9) < 6), $urandom_range(0, 7), mask);
      checkOutput("error_o_random", error_o, model_err);
    end
  endtask

  // Response monitor: pops one expectation per response pulse, flags late or
  // missing responses, and checks that the result outputs hold between pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (victim_valid_o === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_response: victim_valid_o=1 with no request outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("resp_cycle", cyc, mon_e.due);
          checkOutput("victim_none_o", victim_none_o, mon_e.none);
          checkOutput("victim_id_o", victim_id_o, mon_e.id);
          checkOutput("victim_way_o", victim_way_o, mon_e.none ? 0 : (1 << mon_e.id));
          last_none = mon_e.none;
          last_id   = mon_e.id;
          last_way  = mon_e.none ? 0 : (1 << mon_e.id);
        end
      end else begin
        if (expq.size() > 0 && expq[0].due <= cyc) begin
          mon_e = expq.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missing_response: victim_valid_o=0, response due at cycle %0d (cycle %0d)", mon_e.due, cyc);
        end
        checkOutput("hold_victim_id", victim_id_o, last_id);
        checkOutput("hold_victim_way", victim_way_o, last_way);
        checkOutput("hold_victim_none", victim_none_o, last_none);
      end
    end
  end

  initial begin
    modelReset();
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_init_busy", init_busy_o, 1);
    checkOutput("reset_victim_valid", victim_valid_o, 0);
    checkOutput("reset_victim_way", victim_way_o, 0);
    checkOutput("reset_victim_id", victim_id_o, 0);
    checkOutput("reset_victim_none", victim_none_o, 0);
    checkOutput("reset_error", error_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitSweep("reset_sweep_cycles");
    checkOutput("error_after_init_junk", error_o, 0);

    // Directed scenarios in LRU mode.
    applyStimulus(0, 0, '0, 0, 1, 5, '0);
    applyStimulus(1, 3, 8'h80, 0, 0, 0, '0);
    applyStimulus(1, 3, 8'h40, 0, 0, 0, '0);
    applyStimulus(1, 3, 8'h01, 0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, 1, 3, '0);
    applyStimulus(1, 3, 8'h20, 0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, 1, 3, '0);
    applyStimulus(0, 0, '0, 0, 1, 1, 8'hC0);
    applyStimulus(0, 0, '0, 0, 1, 1, 8'hFF);
    applyStimulus(1, 4, 8'h80, 0, 1, 4, '0);
    applyStimulus(0, 0, '0, 0, 1, 4, '0);
    applyStimulus(1, 0, 8'h03, 0, 0, 0, '0);
    checkOutput("error_set", error_o, model_err);
    applyStimulus(0, 0, '0, 0, 1, 0, '0);
    checkOutput("error_sticky", error_o, 1);

    // A mode flip mid-sweep restarts the sweep from set 0.
    mode_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (30) junkCycle();
    update_valid_i = 1'b0;
    victim_req_i   = 1'b0;
    mode_i         = 1'b0;
    model_mode     = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("busy_after_restart", init_busy_o, 1);
    waitSweep("restart_sweep_cycles");
    checkOutput("error_survives_sweep", error_o, 1);

    // FIFO mode: hits do not age a set, fills do.
    changeMode(1'b1, "fifo_sweep_cycles");
    applyStimulus(1, 2, 8'h80, 0, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, 1, 2, '0);
    applyStimulus(1, 2, 8'h80, 1, 0, 0, '0);
    applyStimulus(0, 0, '0, 0, 1, 2, '0);
    randomPhase(250);

    changeMode(1'b0, "lru_sweep_cycles");
    randomPhase(250);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lru_replacement_policy_multiset.md
Name: lru_replacement_policy_multiset

Overview:
- Parametrised successor to the single-set counter-LRU eviction policy.
- Holds per-set age counters for NUM_SETS sets of NUM_WAYS ways.
- Supports LRU and FIFO modes, a per-request way lock mask, and a registered victim-lookup handshake.
- Sits beside the cache controller: the controller reports hits and allocations, and requests eviction victims by set index.

Parameters:
- NUM_WAYS, 8, ways per set; power of 2, >=2
- NUM_SETS, 64, number of sets; power of 2, >=2
- WAY_W, $clog2(NUM_WAYS), derived; way index and age width
- SET_W, $clog2(NUM_SETS), derived; set index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode_i  in  1  0 = LRU, 1 = FIFO
- update_valid_i  in  1  access report strobe
- update_set_i  in  SET_W  set of reported access
- update_way_i  in  NUM_WAYS  one-hot way accessed
- update_alloc_i  in  1  1 = allocation/fill, 0 = hit
- victim_req_i  in  1  victim lookup request
- victim_set_i  in  SET_W  set to look up
- lock_mask_i  in  NUM_WAYS  1 = way excluded from victim selection; sampled with victim_req_i
- victim_valid_o  out  1  one-cycle response pulse
- victim_way_o  out  NUM_WAYS  one-hot victim
- victim_id_o  out  WAY_W  binary victim index
- victim_none_o  out  1  all ways locked; no victim
- init_busy_o  out  1  state sweep in progress
- error_o  out  1  sticky: update_way_i not one-hot

Behaviour:
- Storage: age[set][way], WAY_W bits each. Within a set, ages are always a permutation of 0..NUM_WAYS-1. 0 = MRU, NUM_WAYS-1 = LRU.
- FSM states: INIT, IDLE.
  - rst_n low -> INIT, sweep pointer = 0, all outputs 0 except init_busy_o = 1.
  - INIT: writes age[ptr][i] = i for all ways, one set per cycle, ptr++. After writing set NUM_SETS-1 -> IDLE. INIT lasts exactly NUM_SETS cycles after reset release.
  - IDLE: a change of mode_i vs its registered copy -> INIT, ptr = 0, same cycle.
  - A mode_i change during INIT restarts the sweep at ptr = 0.
- During INIT:
  - update_valid_i and victim_req_i are ignored; no state change from them.
  - victim_valid_o stays 0.
  - Requests are not queued.
- Update, IDLE, update_valid_i = 1, update_way_i one-hot way w with age a:
  - LRU mode, hit or alloc: every way in the set with age < a increments; way w gets age 0; ages > a are unchanged.
  - FIFO mode: applied only when update_alloc_i = 1. Hits cause no change.
  - Takes effect at the next clock edge.
- Invalid update_way_i: zero or multiple bits set with update_valid_i = 1 -> no state change, error_o set to 1. error_o is cleared only by reset.
- Victim lookup, IDLE, victim_req_i = 1:
  - Evaluated on current (pre-edge) state; response registered, so victim_valid_o = 1 exactly one cycle later, for one cycle.
  - Victim = unlocked way with the highest age. Ages are unique, so there are no ties.
  - All ways locked: victim_none_o = 1, victim_way_o = 0, victim_id_o = 0, victim_valid_o = 1.
  - victim_way_o, victim_id_o and victim_none_o hold their value until the next response. All are 0 after reset.
  - Back-to-back requests every cycle are supported, each answered one cycle later.
- Simultaneous update and victim request to the same set in the same cycle: the victim reflects state before the update.
- Different sets in the same cycle are independent.
- No backpressure; the controller must accept each response pulse.

Test Plan:
- Reset, then idle NUM_SETS = 64 cycles -> init_busy_o high for exactly 64 cycles. A victim request on set 5 at cycle 70 -> victim_valid_o next cycle, victim_id_o = 7, victim_way_o = 8'h80.
- LRU, set 3: hit ways 7, 6, 0 in successive cycles, then request victim -> victim_id_o = 5. Then hit way 5, request -> victim_id_o = 4.
- FIFO, set 2: hit way 7 (alloc = 0), request -> victim_id_o = 7. Alloc way 7, request -> victim_id_o = 6.
- Lock: set 1 at init, lock_mask_i = 8'hC0 -> victim_id_o = 5. lock_mask_i = 8'hFF -> victim_none_o = 1, victim_way_o = 0.
- Same-cycle update(set 4, way 7, hit) + victim request(set 4) -> victim_id_o = 7. Repeat request next cycle -> victim_id_o = 6.
- Toggle mode_i at INIT cycle 30 -> sweep restarts, init_busy_o low 64 cycles after the toggle. update_way_i = 8'h03 in IDLE -> error_o = 1 sticky, ages unchanged (victim still 7).
